// File: rtl/prince_sbox_layer_serial_if.sv
// rtl/prince_sbox_layer_serial_if.sv - valid/ready state-in / result-out bundle for the PRINCE S-layer
interface prince_sbox_layer_serial_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    // master = upstream/downstream side, slave = S-layer engine
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );
endinterface

// File: rtl/prince_sbox_layer_serial.sv
// rtl/prince_sbox_layer_serial.sv - forward PRINCE S-layer, NIBBLES_PER_CYCLE nibbles per BUSY cycle
// NIBBLES_PER_CYCLE must divide 16 (1, 2, 4, 8 or 16).
module prince_sbox_layer_serial #(
    parameter int NIBBLES_PER_CYCLE = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    prince_sbox_layer_serial_if.slave   bus
);

    localparam int NPC = NIBBLES_PER_CYCLE;
    localparam int G   = 16 / NPC;
    localparam int CW  = (G > 1) ? $clog2(G) : 1;
    localparam logic [CW-1:0] LAST_GRP = CW'(G - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t          fsm;
    fsm_t          fsm_nxt;
    logic [CW-1:0] cnt;
    logic [63:0]   state_reg;
    logic [63:0]   sub_data;
    logic          out_valid_q;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'hB;
            4'h1:    y = 4'hF;
            4'h2:    y = 4'h3;
            4'h3:    y = 4'h2;
            4'h4:    y = 4'hA;
            4'h5:    y = 4'hC;
            4'h6:    y = 4'h9;
            4'h7:    y = 4'h1;
            4'h8:    y = 4'h6;
            4'h9:    y = 4'h7;
            4'hA:    y = 4'h8;
            4'hB:    y = 4'h0;
            4'hC:    y = 4'hE;
            4'hD:    y = 4'h5;
            4'hE:    y = 4'hD;
            default: y = 4'h4;
        endcase
        return y;
    endfunction

    // Only the nibbles of group cnt are substituted; the rest pass through.
    always_comb begin
        sub_data = state_reg;
        for (int i = 0; i < 16; i++) begin
            if (CW'(i / NPC) == cnt) begin
                sub_data[4*i +: 4] = sbox(state_reg[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (bus.in_valid)  fsm_nxt = BUSY;
            BUSY:    if (cnt == LAST_GRP) fsm_nxt = DONE;
            DONE:    if (bus.out_ready) fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (fsm == IDLE);
        bus.busy     = (fsm == BUSY) || (fsm == DONE);
    end

    // out_valid is registered alongside the DONE transition so it never glitches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            state_reg   <= 64'h0;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_reg <= bus.in_data;
                        cnt       <= '0;
                    end
                end
                BUSY: begin
                    state_reg <= sub_data;
                    if (cnt == LAST_GRP) begin
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = state_reg;

endmodule

// File: tb/tb_prince_sbox_layer_serial.sv
// tb/tb_prince_sbox_layer_serial.sv - scoreboard bench for the serial PRINCE S-layer
module tb_prince_sbox_layer_serial;

    localparam logic [3:0] SBOX [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                         4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
    localparam logic [3:0] SINV [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                                         4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};
    localparam int MAIN_G = 4;
    localparam int TMO    = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    prince_sbox_layer_serial_if bus();

    prince_sbox_layer_serial #(.NIBBLES_PER_CYCLE(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic        sw_in_valid  [4];
    logic [63:0] sw_in_data   [4];
    logic        sw_out_ready [4];
    logic        sw_in_ready  [4];
    logic        sw_out_valid [4];
    logic        sw_busy      [4];
    logic [63:0] sw_out_data  [4];

    for (genvar j = 0; j < 4; j++) begin : g_sweep
        localparam int NPC = (j == 0) ? 1 : (j == 1) ? 2 : (j == 2) ? 8 : 16;
        prince_sbox_layer_serial_if sbus();
        assign sbus.in_valid   = sw_in_valid[j];
        assign sbus.in_data    = sw_in_data[j];
        assign sbus.out_ready  = sw_out_ready[j];
        assign sw_in_ready[j]  = sbus.in_ready;
        assign sw_out_valid[j] = sbus.out_valid;
        assign sw_busy[j]      = sbus.busy;
        assign sw_out_data[j]  = sbus.out_data;
        prince_sbox_layer_serial #(.NIBBLES_PER_CYCLE(NPC)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sbus)
        );
    end

    function automatic logic [63:0] ref_slayer(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = SBOX[d[4*i +: 4]];
        return r;
    endfunction

    function automatic logic [63:0] ref_inv(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = SINV[d[4*i +: 4]];
        return r;
    endfunction

    // Presents one word on the main port for exactly one accepting edge; caller ensures IDLE.
    task automatic drive_main(input logic [63:0] d);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=%h", bus.out_data, 64'h0); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_vectors();
        logic [63:0] vec [3];
        logic [63:0] exp_v;
        int lat;
        vec[0] = 64'h0123456789ABCDEF;
        vec[1] = 64'h0;
        vec[2] = 64'hFFFFFFFFFFFFFFFF;
        bus.out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            exp_q.push_back(ref_slayer(vec[v]));
            drive_main(vec[v]);
            n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL vec%0d_busy got=%b exp=1", v, bus.busy); end
            lat = 0;
            while (bus.out_valid !== 1'b1 && lat < TMO) begin @(negedge clk); lat++; end
            exp_v = exp_q.pop_front();
            n_checks++; if (lat !== MAIN_G) begin n_fail++; $display("FAIL vec%0d_latency got=%0d exp=%0d", v, lat, MAIN_G); end
            n_checks++; if (bus.out_data !== exp_v) begin n_fail++; $display("FAIL vec%0d_data got=%h exp=%h", v, bus.out_data, exp_v); end
            @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL vec%0d_valid_drop got=%b exp=0", v, bus.out_valid); end
            n_checks++; if (bus.out_data !== exp_v) begin n_fail++; $display("FAIL vec%0d_data_hold got=%h exp=%h", v, bus.out_data, exp_v); end
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL vec%0d_idle got=%b exp=1", v, bus.in_ready); end
        end
        n_checks++; if (64'(ref_slayer(64'h0123456789ABCDEF)) !== 64'hBF32AC916780E5D4) begin n_fail++; $display("FAIL ref_model got=%h exp=%h", ref_slayer(64'h0123456789ABCDEF), 64'hBF32AC916780E5D4); end
    endtask

    task automatic test_backpressure();
        logic [63:0] a = 64'hDEADBEEF01234567;
        logic [63:0] b = 64'h13579BDF2468ACE0;
        logic [63:0] exp_v;
        int lat = 0;
        bus.out_ready = 1'b0;
        exp_q.push_back(ref_slayer(a));
        drive_main(a);
        while (bus.out_valid !== 1'b1 && lat < TMO) begin @(negedge clk); lat++; end
        exp_v = exp_q.pop_front();
        n_checks++; if (lat !== MAIN_G) begin n_fail++; $display("FAIL bp_latency got=%0d exp=%0d", lat, MAIN_G); end
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = (c == 3);
            bus.in_data  = b;
            @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_c%0d got=%b exp=1", c, bus.out_valid); end
            n_checks++; if (bus.out_data !== exp_v) begin n_fail++; $display("FAIL bp_data_c%0d got=%h exp=%h", c, bus.out_data, exp_v); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_c%0d got=%b exp=0", c, bus.in_ready); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_idle got=%b exp=1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b exp=0", bus.out_valid); end
        exp_q.push_back(ref_slayer(b));
        drive_main(b);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < TMO) begin @(negedge clk); lat++; end
        exp_v = exp_q.pop_front();
        n_checks++; if (bus.out_data !== exp_v) begin n_fail++; $display("FAIL bp_second_data got=%h exp=%h", bus.out_data, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [63:0] a = 64'hA5A5A5A5C3C3C3C3;
        logic [63:0] b = 64'h0F1E2D3C4B5A6978;
        logic [63:0] exp_v;
        int lat = 0;
        bus.out_ready = 1'b1;
        exp_q.push_back(ref_slayer(a));
        drive_main(a);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 64'h0) begin n_fail++; $display("FAIL rstmid_data got=%h exp=%h", bus.out_data, 64'h0); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got=%b exp=1", bus.in_ready); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_emit_c%0d got=%b exp=0", c, bus.out_valid); end
        end
        exp_q.push_back(ref_slayer(b));
        drive_main(b);
        while (bus.out_valid !== 1'b1 && lat < TMO) begin @(negedge clk); lat++; end
        exp_v = exp_q.pop_front();
        n_checks++; if (lat !== MAIN_G) begin n_fail++; $display("FAIL rstmid_next_latency got=%0d exp=%0d", lat, MAIN_G); end
        n_checks++; if (bus.out_data !== exp_v) begin n_fail++; $display("FAIL rstmid_next_data got=%h exp=%h", bus.out_data, exp_v); end
        @(negedge clk);
    endtask

    task automatic test_param_sweep(input int j);
        int npc_list [4] = '{1, 2, 8, 16};
        int g = 16 / npc_list[j];
        int lat;
        logic [63:0] d;
        logic [63:0] exp_v;
        sw_out_ready[j] = 1'b1;
        exp_q.delete();
        for (int n = 0; n < 1000; n++) begin
            d = {$urandom, $urandom};
            exp_q.push_back(ref_slayer(d));
            sw_in_data[j]  = d;
            sw_in_valid[j] = 1'b1;
            @(negedge clk);
            sw_in_valid[j] = 1'b0;
            lat = 0;
            while (sw_out_valid[j] !== 1'b1 && lat < TMO) begin @(negedge clk); lat++; end
            exp_v = exp_q.pop_front();
            n_checks++; if (lat !== g) begin n_fail++; $display("FAIL sweep_npc%0d_latency n=%0d got=%0d exp=%0d", npc_list[j], n, lat, g); end
            n_checks++; if (sw_out_data[j] !== exp_v) begin n_fail++; $display("FAIL sweep_npc%0d_data n=%0d got=%h exp=%h", npc_list[j], n, sw_out_data[j], exp_v); end
            n_checks++; if (ref_inv(sw_out_data[j]) !== d) begin n_fail++; $display("FAIL sweep_npc%0d_roundtrip n=%0d got=%h exp=%h", npc_list[j], n, ref_inv(sw_out_data[j]), d); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int pushed = 0;
        int got = 0;
        int last_cyc = -1;
        int cyc = 0;
        logic [63:0] d;
        logic [63:0] exp_v;
        exp_q.delete();
        bus.out_ready = 1'b1;
        while (got < 8 && cyc < 200) begin
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL b2b_duplicate got=%h exp=none", bus.out_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    n_checks++; if (bus.out_data !== exp_v) begin n_fail++; $display("FAIL b2b_data got=%h exp=%h", bus.out_data, exp_v); end
                end
                if (last_cyc >= 0) begin
                    n_checks++; if (cyc - last_cyc !== MAIN_G + 2) begin n_fail++; $display("FAIL b2b_interval got=%0d exp=%0d", cyc - last_cyc, MAIN_G + 2); end
                end
                last_cyc = cyc;
                got++;
            end
            if (bus.in_ready === 1'b1) begin
                if (pushed < 8) begin
                    d = {$urandom, $urandom};
                    bus.in_data  = d;
                    bus.in_valid = 1'b1;
                    exp_q.push_back(ref_slayer(d));
                    pushed++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_checks++; if (got !== 8) begin n_fail++; $display("FAIL b2b_count got=%0d exp=8", got); end
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 64'h0;
        bus.out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            sw_in_valid[j]  = 1'b0;
            sw_in_data[j]   = 64'h0;
            sw_out_ready[j] = 1'b1;
        end
        @(negedge clk);
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        for (int j = 0; j < 4; j++) test_param_sweep(j);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
